// File: rtl/dff_shift_ctrl.sv
// Purpose: serializes a parallel word MSB first onto a registered bit with a per-bit strobe.
// Latency: first bit is valid one cycle after the handshake; done pulses with the last bit; in_ready returns one cycle later.
// Backpressure: in_ready is low while busy; stall freezes shifting with ser_en low.
//
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   in_valid, in_data   - producer word, accepted when in_valid && in_ready
//   in_ready            - high in IDLE only (combinational)
//   stall               - freezes SHIFT for the current cycle
//   ser_out, ser_en     - registered serial bit and its one-cycle strobe
//   busy                - high whenever not IDLE (combinational)
//   done                - registered one-cycle pulse alongside the final strobe
//
// Build option: define DFF_SHIFT_CTRL_PARITY_EN to append an even-parity bit
// after bit 0 of every word.

module dff_shift_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             stall,
    output logic             ser_out,
    output logic             ser_en,
    output logic             busy,
    output logic             done
);

`ifdef DFF_SHIFT_CTRL_PARITY_EN
    // One extra emission slot carries the parity bit, so cnt reaches WIDTH.
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif
    localparam int CNT_W = $clog2(LAST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
`ifdef DFF_SHIFT_CTRL_PARITY_EN
    logic             par;
`endif

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            ser_out <= 1'b0;
            ser_en  <= 1'b0;
            done    <= 1'b0;
`ifdef DFF_SHIFT_CTRL_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ser_en <= 1'b0;
                    done   <= 1'b0;
                    if (in_valid) begin
                        shreg <= in_data;
                        cnt   <= '0;
                        state <= SHIFT;
`ifdef DFF_SHIFT_CTRL_PARITY_EN
                        // Parity is taken from the captured word, not the live bus.
                        par   <= ^in_data;
`endif
                    end
                end

                SHIFT: begin
                    if (!stall) begin
`ifdef DFF_SHIFT_CTRL_PARITY_EN
                        ser_out <= (cnt == LAST_CNT) ? par : shreg[WIDTH-1];
`else
                        ser_out <= shreg[WIDTH-1];
`endif
                        ser_en  <= 1'b1;
                        shreg   <= shreg << 1;
                        if (cnt == LAST_CNT) begin
                            // Hold cnt at its final value rather than wrap.
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        // Stalled: strobe drops, ser_out/shreg/cnt hold.
                        ser_en <= 1'b0;
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    done   <= 1'b0;
                    ser_en <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    done   <= 1'b0;
                    ser_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_shift_ctrl.sv
// Bench for dff_shift_ctrl: directed scenarios followed by random traffic,
// compared every cycle against a queue-of-expected-bits transaction model.
// Honours DFF_SHIFT_CTRL_PARITY_EN the same way the design does.

module tb_dff_shift_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         stall;
    logic         ser_out;
    logic         ser_en;
    logic         busy;
    logic         done;

    dff_shift_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .stall    (stall),
        .ser_out  (ser_out),
        .ser_en   (ser_en),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Transaction model: a word is a list of bits still to be emitted.
    logic q[$];
    logic active  = 1'b0;
    logic exp_out = 1'b0;
    logic exp_en  = 1'b0;
    logic exp_dn  = 1'b0;
    logic exp_bsy = 1'b0;
    int   strobes = 0;
    int   dones   = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic load_word(input logic [W-1:0] w);
        q.delete();
        for (int i = W - 1; i >= 0; i--) q.push_back(w[i]);
`ifdef DFF_SHIFT_CTRL_PARITY_EN
        q.push_back(^w);
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, check after it.
    task automatic step(input logic r, input logic v, input logic [W-1:0] d, input logic s);
        reset    = r;
        in_valid = v;
        in_data  = d;
        stall    = s;
        @(posedge clk);
        cyc++;
        if (r) begin
            q.delete();
            active  = 1'b0;
            exp_out = 1'b0;
            exp_en  = 1'b0;
            exp_dn  = 1'b0;
        end else if (!active) begin
            exp_en = 1'b0;
            exp_dn = 1'b0;
            if (v) begin
                load_word(d);
                active = 1'b1;
            end
        end else if (q.size() > 0) begin
            exp_dn = 1'b0;
            if (s) begin
                exp_en = 1'b0;
            end else begin
                exp_out = q.pop_front();
                exp_en  = 1'b1;
                exp_dn  = (q.size() == 0);
            end
        end else begin
            // Word fully emitted: the done cycle ends here.
            active = 1'b0;
            exp_en = 1'b0;
            exp_dn = 1'b0;
        end
        exp_bsy = active;
        #1;
        chk("ser_out", ser_out, exp_out);
        chk("ser_en", ser_en, exp_en);
        chk("done", done, exp_dn);
        chk("busy", busy, exp_bsy);
        chk("in_ready", in_ready, ~exp_bsy);
        if (ser_en === 1'b1) strobes++;
        if (done === 1'b1) dones++;
    endtask

    initial begin
        int exp_strobes;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        stall    = 1'b0;
`ifdef DFF_SHIFT_CTRL_PARITY_EN
        exp_strobes = W + 1;
`else
        exp_strobes = W;
`endif

        // Reset state.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Word 0xA5, no stalls; also count strobes and done pulses per word.
        strobes = 0;
        dones   = 0;
        step(1'b0, 1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < W + 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("a5_strobes", (strobes == exp_strobes), 1'b1);
        chk("a5_dones", (dones == 1), 1'b1);

        // Word 0x3C with three stall cycles after the third bit.
        step(1'b0, 1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < W + 6; i++)
            step(1'b0, 1'b0, 8'h00, (i >= 3 && i < 6));

        // in_valid held high: 0x81 then 0xFF accepted on first idle cycle.
        for (int i = 0; i < 2 * (exp_strobes + 2) + 2; i++)
            step(1'b0, 1'b1, (i < exp_strobes + 2) ? 8'h81 : 8'hFF, 1'b0);
        for (int i = 0; i < W + 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset during the 4th bit of 0xF0; no done pulse, then 0x0F.
        dones = 0;
        step(1'b0, 1'b1, 8'hF0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("abort_no_done", (dones == 0), 1'b1);
        step(1'b0, 1'b1, 8'h0F, 1'b0);
        for (int i = 0; i < W + 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset, in_valid and stall together: no handshake.
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Word 0x07 (parity bit 1 when enabled).
        strobes = 0;
        step(1'b0, 1'b1, 8'h07, 1'b0);
        for (int i = 0; i < W + 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("07_strobes", (strobes == exp_strobes), 1'b1);

        // Random traffic, including mid-word resets and in_data churn while busy.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(199) == 0), $urandom_range(1) == 1,
                 W'($urandom), ($urandom_range(3) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
